pwm_multi_channel: RTL and testbench

// - Parametrised successor to the fixed 16-channel/8-bit PWM peripheral: NUM_CH channels, CNT_W-bit counter.
// - Adds a programmable period, a clock prescaler, per-channel duty registers and glitch-free double-buffered duty updates.
// - Sits between the SPI register file (enables, duty writes, period, prescale) and the top-level out pins.

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_prescaler.sv | 23 ++
 rtl/pwm_multi_channel.sv | 78 +++++++
 tb/tb_pwm_multi_channel.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and types for the multi-channel PWM block and its timers.
package pwm_pkg;
  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 8;
  localparam int CH_IDX_W    = $clog2(DEF_NUM_CH);

  typedef logic [DEF_CNT_W-1:0] duty_t;
endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-cycle tick every prescale+1 clocks, prescale read live.
// Tick is combinational from the count register; free-running, no backpressure.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;

  // >= so that lowering prescale below the running count ends the wait at once
  assign tick        = (presc_cnt_q >= prescale);
  assign presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) presc_cnt_q <= '0;
    else        presc_cnt_q <= presc_cnt_d;
  end
endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH-channel PWM with programmable period/prescale and double-buffered duty.
// Outputs registered one clk after counter/active duty; writes are never stalled.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         en_out,
  input  logic [NUM_CH-1:0]         en_pwm,
  input  logic                      duty_wr,
  input  logic [$clog2(NUM_CH)-1:0] duty_ch,
  input  logic [CNT_W-1:0]          duty_val,
  input  logic [CNT_W-1:0]          period,
  input  logic [PRESC_W-1:0]        prescale,
  output logic [NUM_CH-1:0]         out,
  output logic                      period_start
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic              tick, wrap;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  pending_q [NUM_CH];
  logic [CNT_W-1:0]  pending_d [NUM_CH];
  logic [CNT_W-1:0]  active_q  [NUM_CH];
  logic [CNT_W-1:0]  active_d  [NUM_CH];
  logic [NUM_CH-1:0] wr_sel, cmp_hi, out_q, out_d;
  logic              period_start_q;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .prescale (prescale),
    .tick     (tick)
  );

  // >= lets a live period reduction below cnt wrap on the next tick
  assign wrap = tick && (cnt_q >= period);

  always_comb begin
    cnt_d = cnt_q;
    if (wrap)      cnt_d = '0;
    else if (tick) cnt_d = cnt_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i]    = duty_wr && (duty_ch == IDX_W'(i));
    // active loads from pending_d so a write on the wrap cycle reaches the new period
    assign pending_d[i] = wr_sel[i] ? duty_val : pending_q[i];
    assign active_d[i]  = wrap ? pending_d[i] : active_q[i];
    assign cmp_hi[i]    = cnt_q < active_q[i];
    assign out_d[i]     = en_out[i] && (!en_pwm[i] || cmp_hi[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      out_q          <= out_d;
      period_start_q <= wrap;
      pending_q      <= pending_d;
      active_q       <= active_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: directed period/duty measurements plus a random
// phase, all checked against an integer reference model of the PWM rules.
module tb_pwm_multi_channel;
  localparam int NCH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  en_out, en_pwm;
  logic            duty_wr;
  logic [3:0]      duty_ch;
  logic [7:0]      duty_val, period, prescale;
  logic [NCH-1:0]  out;
  logic            period_start;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_multi_channel dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty_wr      (duty_wr),
    .duty_ch      (duty_ch),
    .duty_val     (duty_val),
    .period       (period),
    .prescale     (prescale),
    .out          (out),
    .period_start (period_start)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: clocks since last tick, tick position in the period,
  // pending/active duty tables; writes land before the period-boundary copy.
  int             m_sub, m_pos;
  int             m_pend [NCH];
  int             m_act  [NCH];
  logic [NCH-1:0] m_out;
  logic           m_ps;

  always @(posedge clk) begin
    bit m_tick, m_wrap;
    if (!rst_n) begin
      m_sub = 0; m_pos = 0; m_out = '0; m_ps = 1'b0;
      for (int i = 0; i < NCH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
    end else begin
      m_tick = (m_sub >= int'(prescale));
      m_wrap = m_tick && (m_pos >= int'(period));
      for (int i = 0; i < NCH; i++)
        m_out[i] = !en_out[i] ? 1'b0 : (!en_pwm[i] ? 1'b1 : (m_pos < m_act[i]));
      if (duty_wr) m_pend[int'(duty_ch)] = int'(duty_val);
      if (m_wrap) for (int i = 0; i < NCH; i++) m_act[i] = m_pend[i];
      m_ps  = m_wrap;
      m_sub = m_tick ? 0 : m_sub + 1;
      if (m_wrap)      m_pos = 0;
      else if (m_tick) m_pos = m_pos + 1;
    end
  end

  bit mon_en = 1'b0;
  int mm     = 0;
  always @(negedge clk)
    if (mon_en && (out !== m_out || period_start !== m_ps)) mm++;

  task automatic wait_ps(input int budget, output int n, output int nz);
    n = 0; nz = 0;
    do begin
      @(negedge clk);
      duty_wr = 1'b0;
      n++;
      if (out != '0) nz++;
    end while (period_start !== 1'b1 && n < budget);
    if (period_start !== 1'b1) chk("ps_timeout", period_start, 1);
  endtask

  task automatic count_high(input int ch, input int ncyc, input int wr_at, input int wch,
                            input int wval, output int hi, output int ps);
    hi = 0; ps = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      duty_wr = 1'b0;
      hi += int'(out[ch]);
      ps += int'(period_start);
      if (k == wr_at) begin
        duty_wr = 1'b1; duty_ch = 4'(wch); duty_val = 8'(wval);
      end
    end
  endtask

  task automatic model_chk(input string tag);
    chk(tag, mm, 0);
    mm = 0;
  endtask

  initial begin
    int n, nz, hi, ps;
    rst_n = 1'b0; en_out = '1; en_pwm = '1; duty_wr = 1'b0;
    duty_ch = '0; duty_val = '0; period = 8'd255; prescale = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_out", out, 0);
    chk("reset_ps", period_start, 0);
    mon_en = 1'b1;

    // T1: 256-clk period, ch0 at 50 %
    rst_n = 1'b1; duty_wr = 1'b1; duty_ch = 4'd0; duty_val = 8'd128;
    wait_ps(600, n, nz);
    chk("T1_first_ps", n, 256);
    chk("T1_low_before_wrap", nz, 0);
    count_high(0, 256, -1, 0, 0, hi, ps);
    chk("T1_hi", hi, 128); chk("T1_ps", ps, 1);
    count_high(0, 256, 100, 2, 60, hi, ps);
    chk("T1_hi_rep", hi, 128); chk("T1_ps_rep", ps, 1);
    model_chk("T1_model");

    // T2: prescale 3, period 99 -> 400 clks
    prescale = 8'd3; period = 8'd99; duty_wr = 1'b1; duty_ch = 4'd1; duty_val = 8'd25;
    wait_ps(1000, n, nz);
    chk("T2_first_period", n, 400);
    count_high(1, 400, -1, 0, 0, hi, ps);
    chk("T2_hi", hi, 100); chk("T2_ps", ps, 1);
    wait_ps(1000, n, nz);
    chk("T2_period", n, 400);
    model_chk("T2_model");

    // T3: duty 0 and duty above period
    duty_wr = 1'b1; duty_ch = 4'd2; duty_val = 8'd0;
    @(negedge clk);
    duty_ch = 4'd3; duty_val = 8'd200;
    wait_ps(1000, n, nz);
    count_high(2, 400, -1, 0, 0, hi, ps);
    chk("T3_duty0", hi, 0);
    count_high(3, 400, -1, 0, 0, hi, ps);
    chk("T3_duty_gt_period", hi, 400);
    model_chk("T3_model");

    // T4: mid-period write deferred, wrap-cycle write forwarded
    prescale = 8'd0; period = 8'd255;
    wait_ps(1000, n, nz);
    count_high(0, 256, 9, 0, 64, hi, ps);
    chk("T4_cur_unchanged", hi, 128);
    count_high(0, 256, 254, 0, 32, hi, ps);
    chk("T4_next_64", hi, 64);
    count_high(0, 256, 5, 4, 200, hi, ps);
    chk("T4_wrap_fwd_32", hi, 32);
    model_chk("T4_model");

    // T5: enables act on the next clk
    en_out[4] = 1'b0; en_pwm[5] = 1'b0;
    @(negedge clk);
    chk("T5_out4_off", out[4], 0);
    chk("T5_out5_static", out[5], 1);
    count_high(5, 256, -1, 0, 0, hi, ps);
    chk("T5_out5_hi", hi, 256);
    count_high(4, 256, -1, 0, 0, hi, ps);
    chk("T5_out4_hi", hi, 0);
    en_out = '1; en_pwm = '1;
    model_chk("T5_model");

    // T6: mid-period reset, then live period reduction
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("T6_rst_out", out, 0);
    chk("T6_rst_ps", period_start, 0);
    rst_n = 1'b1;
    wait_ps(600, n, nz);
    chk("T6_first_ps", n, 256);
    chk("T6_out_zero", nz, 0);
    repeat (100) @(negedge clk);
    period = 8'd20;
    wait_ps(600, n, nz);
    chk("T6_forced_wrap", n, 1);
    wait_ps(600, n, nz);
    chk("T6_short_period", n, 21);
    model_chk("T6_model");

    // T7: maximum prescale
    period = 8'd3; prescale = 8'd255;
    wait_ps(2000, n, nz);
    chk("T7_max_presc", n, 1024);
    wait_ps(2000, n, nz);
    chk("T7_max_presc_rep", n, 1024);
    model_chk("T7_model");

    // Random traffic against the model
    period = 8'd12; prescale = 8'd1;
    for (int c = 0; c < 4000; c++) begin
      int b;
      @(negedge clk);
      duty_wr  = ($urandom_range(0, 3) == 0);
      duty_ch  = 4'($urandom_range(0, 15));
      duty_val = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 199) == 0) period   = 8'($urandom_range(0, 30));
      if ($urandom_range(0, 299) == 0) prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin b = $urandom_range(0, 15); en_out[b] = ~en_out[b]; end
      if ($urandom_range(0, 49) == 0) begin b = $urandom_range(0, 15); en_pwm[b] = ~en_pwm[b]; end
      rst_n = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    duty_wr = 1'b0; rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_chk("RND_model");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
